icmp_echo_tx: RTL

ICMP_ECHO_TX -- requirements
Module: icmp_echo_tx

---
 rtl/icmp_echo_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/icmp_echo_tx.sv
// ICMP echo request/reply frame generator: buffers a payload, folds the
// Internet checksum on the fly, then streams the 8-byte header plus payload.
module icmp_echo_tx #(
  parameter int unsigned P_MAX_PLD = 32,
  parameter int unsigned P_CNT_W   = 11
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_pld_data,
  input  logic               i_pld_valid,
  input  logic               i_trig,
  input  logic               i_mode,
  input  logic [15:0]        i_trig_id,
  input  logic [15:0]        i_trig_seq,
  output logic [7:0]         o_icmp_data,
  output logic [P_CNT_W-1:0] o_icmp_len,
  output logic               o_icmp_valid,
  output logic               o_icmp_last,
  input  logic               i_icmp_ready,
  output logic               o_busy
);

  localparam int unsigned        AW      = (P_MAX_PLD > 1) ? $clog2(P_MAX_PLD) : 1;
  localparam logic [P_CNT_W-1:0] MAX_CNT = P_CNT_W'(P_MAX_PLD);
  localparam logic [P_CNT_W-1:0] HDR_LEN = P_CNT_W'(8);

  typedef enum logic [2:0] {IDLE, SUM1, SUM2, INV, SEND} state_e;

  state_e             state_q, state_d;
  logic [P_CNT_W-1:0] pld_cnt_q, pld_cnt_d;
  logic [P_CNT_W-1:0] len_q, len_d;
  logic [P_CNT_W-1:0] idx_q, idx_d;
  logic [31:0]        acc_q, acc_d;
  logic [15:0]        csum_q, csum_d;
  logic [15:0]        id_q, id_d;
  logic [15:0]        seq_q, seq_d;
  logic               mode_q, mode_d;
  logic [7:0]         mem_q [P_MAX_PLD];

  logic               pld_wr;
  logic [31:0]        pld_term;
  logic [31:0]        hdr_term;
  logic [7:0]         type_byte;
  logic [AW-1:0]      rd_addr;
  logic               accept;
  logic               last_byte;

  assign pld_wr    = (state_q == IDLE) && i_pld_valid && (pld_cnt_q < MAX_CNT);
  assign pld_term  = pld_cnt_q[0] ? {24'h0, i_pld_data} : {16'h0, i_pld_data, 8'h00};
  assign hdr_term  = {16'h0, (i_mode ? 8'h08 : 8'h00), 8'h00}
                   + {16'h0, i_trig_id} + {16'h0, i_trig_seq};
  assign type_byte = mode_q ? 8'h08 : 8'h00;
  assign rd_addr   = AW'(idx_q - HDR_LEN);

  assign o_icmp_valid = (state_q == SEND);
  assign o_busy       = (state_q != IDLE);
  assign o_icmp_len   = len_q;
  assign last_byte    = (idx_q == len_q - P_CNT_W'(1));
  assign o_icmp_last  = o_icmp_valid && last_byte;
  assign accept       = o_icmp_valid && i_icmp_ready;

  always_comb begin
    o_icmp_data = '0;
    if (o_icmp_valid) begin
      if (idx_q < HDR_LEN) begin
        case (idx_q[2:0])
          3'd0:    o_icmp_data = type_byte;
          3'd1:    o_icmp_data = 8'h00;
          3'd2:    o_icmp_data = csum_q[15:8];
          3'd3:    o_icmp_data = csum_q[7:0];
          3'd4:    o_icmp_data = id_q[15:8];
          3'd5:    o_icmp_data = id_q[7:0];
          3'd6:    o_icmp_data = seq_q[15:8];
          default: o_icmp_data = seq_q[7:0];
        endcase
      end else begin
        o_icmp_data = mem_q[rd_addr];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pld_cnt_d = pld_cnt_q;
    len_d     = len_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    csum_d    = csum_q;
    id_d      = id_q;
    seq_d     = seq_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: begin
        if (pld_wr) begin
          pld_cnt_d = pld_cnt_q + P_CNT_W'(1);
          acc_d     = acc_q + pld_term;
        end
        // Trigger chains onto the payload update so a same-cycle byte is counted and summed.
        if (i_trig) begin
          mode_d  = i_mode;
          id_d    = i_trig_id;
          seq_d   = i_trig_seq;
          len_d   = HDR_LEN + pld_cnt_d;
          acc_d   = acc_d + hdr_term;
          idx_d   = '0;
          state_d = SUM1;
        end
      end
      SUM1: begin
        acc_d   = {16'h0, acc_q[31:16]} + {16'h0, acc_q[15:0]};
        state_d = SUM2;
      end
      SUM2: begin
        acc_d   = {16'h0, acc_q[31:16]} + {16'h0, acc_q[15:0]};
        state_d = INV;
      end
      INV: begin
        csum_d  = ~acc_q[15:0];
        state_d = SEND;
      end
      SEND: begin
        if (accept) begin
          if (last_byte) begin
            state_d   = IDLE;
            pld_cnt_d = '0;
            acc_d     = '0;
          end else begin
            idx_d = idx_q + P_CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pld_cnt_q <= '0;
      len_q     <= HDR_LEN;
      idx_q     <= '0;
      acc_q     <= '0;
      csum_q    <= '0;
      id_q      <= '0;
      seq_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pld_cnt_q <= pld_cnt_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      csum_q    <= csum_d;
      id_q      <= id_d;
      seq_q     <= seq_d;
      mode_q    <= mode_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (pld_wr) begin
      mem_q[pld_cnt_q[AW-1:0]] <= i_pld_data;
    end
  end

endmodule
